// File: rtl/pump_cmd_sequencer.sv
// Framed byte-command parser and pump configuration register bank for the pump timer.
// Optional inter-byte timeout is built only when PUMP_CMD_TIMEOUT_EN is defined.
module pump_cmd_sequencer #(
  parameter int          CLOCK_FREQ = 1_000_000,
  parameter logic [7:0]  HEADER     = 8'hA5,
  parameter logic [31:0] DEF_PERIOD = 32'd60,
  parameter logic [31:0] DEF_PULSE  = 32'd5,
  parameter int          TIMEOUT_MS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] period_seconds,
  output logic [31:0] pulse_on_time,
  output logic [1:0]  pump_select,
  output logic        timer_start,
  output logic        timer_stop,
  output logic        force_pulse,
  output logic        cmd_ack,
  output logic        cmd_err,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {S_HDR, S_CMD, S_PAY, S_CHK, S_EXEC} state_t;

  localparam logic [7:0] CMD_PERIOD = 8'h01;
  localparam logic [7:0] CMD_PULSE  = 8'h02;
  localparam logic [7:0] CMD_SELECT = 8'h03;
  localparam logic [7:0] CMD_START  = 8'h10;
  localparam logic [7:0] CMD_STOP   = 8'h11;
  localparam logic [7:0] CMD_FORCE  = 8'h12;

  localparam logic [1:0] ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_CHKSUM  = 2'd1;
  localparam logic [1:0] ERR_CMD     = 2'd2;
  localparam logic [1:0] ERR_VALUE   = 2'd3;

  if (TIMEOUT_MS < 1 || CLOCK_FREQ < 1000) begin : g_bad_cfg
    $error("pump_cmd_sequencer: timeout must span at least one clock");
  end

  state_t      state_q;
  logic [1:0]  byte_cnt_q;
  logic [7:0]  cmd_q;
  logic [31:0] pay_q;
  logic [7:0]  chk_q;
  logic        rx_ready_q;
  logic [31:0] period_q;
  logic [31:0] pulse_q;
  logic [1:0]  sel_q;
  logic        start_q;
  logic        stop_q;
  logic        force_q;
  logic        ack_q;
  logic        err_q;
  logic [1:0]  err_code_q;

  logic        accept;
  logic [7:0]  chk_calc;
  logic        exec_err_d;
  logic [1:0]  exec_code_d;

`ifdef PUMP_CMD_TIMEOUT_EN
  localparam int TO_CYC = TIMEOUT_MS * CLOCK_FREQ / 1000;
  localparam int TO_W   = $clog2(TO_CYC + 1);
  logic [TO_W-1:0] to_cnt_q;
`endif

  assign accept   = rx_valid && rx_ready_q;
  assign chk_calc = cmd_q ^ pay_q[31:24] ^ pay_q[23:16] ^ pay_q[15:8] ^ pay_q[7:0];

  // Frame validation: checksum beats command decode, which beats value rules.
  always_comb begin
    exec_err_d  = 1'b0;
    exec_code_d = ERR_TIMEOUT;
    if (chk_calc != chk_q) begin
      exec_err_d  = 1'b1;
      exec_code_d = ERR_CHKSUM;
    end else begin
      case (cmd_q)
        CMD_PERIOD: begin
          if (pay_q == 32'd0 || pulse_q >= pay_q) begin
            exec_err_d  = 1'b1;
            exec_code_d = ERR_VALUE;
          end
        end
        CMD_PULSE: begin
          if (pay_q == 32'd0 || pay_q >= period_q) begin
            exec_err_d  = 1'b1;
            exec_code_d = ERR_VALUE;
          end
        end
        CMD_SELECT: begin
          if (pay_q[1:0] == 2'b00) begin
            exec_err_d  = 1'b1;
            exec_code_d = ERR_VALUE;
          end
        end
        CMD_START, CMD_STOP, CMD_FORCE: ;
        default: begin
          exec_err_d  = 1'b1;
          exec_code_d = ERR_CMD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_HDR;
      byte_cnt_q <= 2'd0;
      rx_ready_q <= 1'b1;
      period_q   <= DEF_PERIOD;
      pulse_q    <= DEF_PULSE;
      sel_q      <= 2'b01;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      force_q    <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_TIMEOUT;
`ifdef PUMP_CMD_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      force_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;

      case (state_q)
        S_HDR: begin
          if (accept && rx_data == HEADER) state_q <= S_CMD;
        end
        S_CMD: begin
          if (accept) begin
            cmd_q      <= rx_data;
            byte_cnt_q <= 2'd0;
            state_q    <= S_PAY;
          end
        end
        S_PAY: begin
          if (accept) begin
            pay_q      <= {pay_q[23:0], rx_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) state_q <= S_CHK;
          end
        end
        S_CHK: begin
          if (accept) begin
            chk_q      <= rx_data;
            rx_ready_q <= 1'b0;
            state_q    <= S_EXEC;
          end
        end
        S_EXEC: begin
          rx_ready_q <= 1'b1;
          state_q    <= S_HDR;
          if (exec_err_d) begin
            err_q      <= 1'b1;
            err_code_q <= exec_code_d;
          end else begin
            ack_q <= 1'b1;
            case (cmd_q)
              CMD_PERIOD: period_q <= pay_q;
              CMD_PULSE:  pulse_q  <= pay_q;
              CMD_SELECT: sel_q    <= pay_q[1:0];
              CMD_START:  start_q  <= 1'b1;
              CMD_STOP:   stop_q   <= 1'b1;
              CMD_FORCE:  force_q  <= 1'b1;
              default: ;
            endcase
          end
        end
        default: state_q <= S_HDR;
      endcase

`ifdef PUMP_CMD_TIMEOUT_EN
      // Inter-byte watchdog only runs while a frame is partially received.
      if (state_q == S_HDR || state_q == S_EXEC || accept) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q == TO_W'(TO_CYC - 1)) begin
        to_cnt_q   <= '0;
        state_q    <= S_HDR;
        err_q      <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
      end else begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
`endif
    end
  end

  assign rx_ready       = rx_ready_q;
  assign period_seconds = period_q;
  assign pulse_on_time  = pulse_q;
  assign pump_select    = sel_q;
  assign timer_start    = start_q;
  assign timer_stop     = stop_q;
  assign force_pulse    = force_q;
  assign cmd_ack        = ack_q;
  assign cmd_err        = err_q;
  assign err_code       = err_code_q;

endmodule
